// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
//   Shared definitions for the piece move engine: command encodings, FSM state
//   enum, default geometry and a helper that classifies an incoming command.
//
//   Optional feature macro: PIECE_ROTATE_EN (enables the ROT_CW command).
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int WIDTH_DEF   = 8;   // bits per coordinate
    localparam int CELLS_DEF   = 4;   // cells per piece
    localparam int FIELD_W_DEF = 10;  // field columns
    localparam int FIELD_H_DEF = 20;  // field rows

    // Encodings 6 and 7 are left undefined on purpose and behave as NOP.
    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_DOWN   = 3'd1,
        CMD_LEFT   = 3'd2,
        CMD_RIGHT  = 3'd3,
        CMD_ROT_CW = 3'd4,
        CMD_LOAD   = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EVAL,
        ST_LOCK,
        ST_DONE
    } state_e;

    // True when the command actually moves or spawns a piece. Anything else
    // (NOP, 6, 7, disabled rotation, or non-LOAD after game over) simply
    // finishes one cycle after accept without touching the piece.
    function automatic logic cmd_does_work(input logic [2:0] cmd, input logic game_over);
        logic active;
        case (cmd)
            CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_LOAD: active = 1'b1;
`ifdef PIECE_ROTATE_EN
            CMD_ROT_CW:                              active = 1'b1;
`endif
            default:                                 active = 1'b0;
        endcase
        return active && (!game_over || (cmd == CMD_LOAD));
    endfunction

endpackage

// File: rtl/piece_candidate.sv
// -----------------------------------------------------------------------------
// piece_candidate
//   Purely combinational: given a command and the current piece, produce the
//   candidate piece coordinates and a flag telling whether any candidate cell
//   lies outside the field. Coordinates are unsigned, so a step left from x=0
//   wraps to a large value and is caught by the same upper-bound test.
//
//   Optional feature macro: PIECE_ROTATE_EN (builds the ROT_CW datapath).
//
// Ports
//   cmd_i      command being accepted
//   cur_x_i    current piece x, CELLS packed WIDTH-bit cells
//   cur_y_i    current piece y
//   load_x_i   spawn x coords (used for LOAD)
//   load_y_i   spawn y coords (used for LOAD)
//   cand_x_o   candidate x coords
//   cand_y_o   candidate y coords
//   oob_o      at least one candidate cell is outside the field
// -----------------------------------------------------------------------------
module piece_candidate
    import tetris_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CELLS   = CELLS_DEF,
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF
) (
    input  logic [2:0]             cmd_i,
    input  logic [CELLS*WIDTH-1:0] cur_x_i,
    input  logic [CELLS*WIDTH-1:0] cur_y_i,
    input  logic [CELLS*WIDTH-1:0] load_x_i,
    input  logic [CELLS*WIDTH-1:0] load_y_i,
    output logic [CELLS*WIDTH-1:0] cand_x_o,
    output logic [CELLS*WIDTH-1:0] cand_y_o,
    output logic                   oob_o
);

    localparam logic [WIDTH-1:0] FW  = WIDTH'(FIELD_W);
    localparam logic [WIDTH-1:0] FH  = WIDTH'(FIELD_H);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef PIECE_ROTATE_EN
    // Rotation pivots on cell 0.
    logic [WIDTH-1:0] x0, y0;
    assign x0 = cur_x_i[WIDTH-1:0];
    assign y0 = cur_y_i[WIDTH-1:0];
`endif

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the case statements can infer a latch.
        cand_x_o = cur_x_i;
        cand_y_o = cur_y_i;
        for (int i = 0; i < CELLS; i++) begin
            case (cmd_i)
                CMD_DOWN:  cand_y_o[i*WIDTH +: WIDTH] = cur_y_i[i*WIDTH +: WIDTH] + ONE;
                CMD_LEFT:  cand_x_o[i*WIDTH +: WIDTH] = cur_x_i[i*WIDTH +: WIDTH] - ONE;
                CMD_RIGHT: cand_x_o[i*WIDTH +: WIDTH] = cur_x_i[i*WIDTH +: WIDTH] + ONE;
`ifdef PIECE_ROTATE_EN
                CMD_ROT_CW: begin
                    // Clockwise in screen coordinates (y grows downward).
                    cand_x_o[i*WIDTH +: WIDTH] = x0 - (cur_y_i[i*WIDTH +: WIDTH] - y0);
                    cand_y_o[i*WIDTH +: WIDTH] = y0 + (cur_x_i[i*WIDTH +: WIDTH] - x0);
                end
`endif
                CMD_LOAD: begin
                    cand_x_o[i*WIDTH +: WIDTH] = load_x_i[i*WIDTH +: WIDTH];
                    cand_y_o[i*WIDTH +: WIDTH] = load_y_i[i*WIDTH +: WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oob_o = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if ((cand_x_o[i*WIDTH +: WIDTH] >= FW) || (cand_y_o[i*WIDTH +: WIDTH] >= FH)) begin
                oob_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piece_move_engine.sv
// -----------------------------------------------------------------------------
// piece_move_engine
//   Holds the active piece and executes one move command at a time. The
//   candidate position is bounds-checked at accept, then each candidate cell is
//   looked up in the field occupancy RAM. A clean move commits; a blocked DOWN
//   writes the current cells into the field (lock); a blocked LOAD spawns
//   anyway and raises the sticky game_over flag.
//
//   Optional feature macro: PIECE_ROTATE_EN (ROT_CW supported; otherwise NOP).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd               command code (tetris_pkg::cmd_e)
//   load_x/load_y     spawn coordinates, sampled when LOAD is accepted
//   occ_rd/x/y        occupancy read request for one cell
//   occ_hit           read result, one cycle after occ_rd
//   wr_en/wr_x/wr_y   lock write, one cell per cycle
//   coord_x/coord_y   current piece coordinates
//   done              one-cycle completion pulse
//   moved/touched     result flags, meaningful only while done=1
//   game_over         sticky: a LOAD spawn was blocked
//
// Timeline (cycle 0 = accept): CHECK issues reads in cycles 1..CELLS, EVAL
// sees the last hit in cycle CELLS+1, DONE follows (or LOCK for CELLS cycles).
// -----------------------------------------------------------------------------
module piece_move_engine
    import tetris_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CELLS   = CELLS_DEF,
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd,
    input  logic [CELLS*WIDTH-1:0] load_x,
    input  logic [CELLS*WIDTH-1:0] load_y,
    output logic                   occ_rd,
    output logic [WIDTH-1:0]       occ_x,
    output logic [WIDTH-1:0]       occ_y,
    input  logic                   occ_hit,
    output logic                   wr_en,
    output logic [WIDTH-1:0]       wr_x,
    output logic [WIDTH-1:0]       wr_y,
    output logic [CELLS*WIDTH-1:0] coord_x,
    output logic [CELLS*WIDTH-1:0] coord_y,
    output logic                   done,
    output logic                   moved,
    output logic                   touched,
    output logic                   game_over
);

    localparam int                BUS_W    = CELLS * WIDTH;
    localparam int                IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CELLS - 1);

    state_e             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [BUS_W-1:0]   cand_x_q, cand_x_d;
    logic [BUS_W-1:0]   cand_y_q, cand_y_d;
    logic [BUS_W-1:0]   coord_x_q, coord_x_d;
    logic [BUS_W-1:0]   coord_y_q, coord_y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rd_pend_q, rd_pend_d;   // a read was issued last cycle
    logic               blocked_q, blocked_d;
    logic               moved_q, moved_d;
    logic               touched_q, touched_d;
    logic               game_over_q, game_over_d;

    logic [BUS_W-1:0]   new_x, new_y;
    logic               new_oob;
    logic               accept, cmd_active, final_blocked, last_idx;

    piece_candidate #(
        .WIDTH   (WIDTH),
        .CELLS   (CELLS),
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_candidate (
        .cmd_i    (cmd),
        .cur_x_i  (coord_x_q),
        .cur_y_i  (coord_y_q),
        .load_x_i (load_x),
        .load_y_i (load_y),
        .cand_x_o (new_x),
        .cand_y_o (new_y),
        .oob_o    (new_oob)
    );

    assign accept        = cmd_valid && (state_q == ST_IDLE);
    assign cmd_active    = cmd_does_work(cmd, game_over_q);
    assign final_blocked = blocked_q || occ_hit;
    assign last_idx      = (idx_q == LAST_IDX);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cmd_active)  state_d = ST_DONE;
                    else if (new_oob) state_d = (cmd == CMD_DOWN) ? ST_LOCK : ST_DONE;
                    else              state_d = ST_CHECK;
                end
            end
            ST_CHECK: if (last_idx) state_d = ST_EVAL;
            ST_EVAL:  state_d = (final_blocked && (cmd_q == CMD_DOWN)) ? ST_LOCK : ST_DONE;
            ST_LOCK:  if (last_idx) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        cmd_d       = cmd_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        coord_x_d   = coord_x_q;
        coord_y_d   = coord_y_q;
        idx_d       = idx_q;
        rd_pend_d   = 1'b0;
        blocked_d   = blocked_q;
        moved_d     = moved_q;
        touched_d   = touched_q;
        game_over_d = game_over_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Coords cannot change before DONE, so the candidate is
                    // frozen here and the load inputs need not be held.
                    cmd_d     = cmd;
                    cand_x_d  = new_x;
                    cand_y_d  = new_y;
                    idx_d     = '0;
                    blocked_d = 1'b0;
                    moved_d   = 1'b0;
                    touched_d = 1'b0;
                    if (cmd_active && new_oob) begin
                        blocked_d = 1'b1;
                        if (cmd == CMD_LOAD) begin
                            coord_x_d   = new_x;
                            coord_y_d   = new_y;
                            game_over_d = 1'b1;
                        end
                    end
                end
            end
            ST_CHECK: begin
                rd_pend_d = 1'b1;
                idx_d     = last_idx ? '0 : idx_q + IDX_W'(1);
                if (rd_pend_q && occ_hit) blocked_d = 1'b1;
            end
            ST_EVAL: begin
                blocked_d = final_blocked;
                idx_d     = '0;
                if (!final_blocked) begin
                    coord_x_d = cand_x_q;
                    coord_y_d = cand_y_q;
                    moved_d   = 1'b1;
                end else if (cmd_q == CMD_LOAD) begin
                    coord_x_d   = cand_x_q;
                    coord_y_d   = cand_y_q;
                    game_over_d = 1'b1;
                end
            end
            ST_LOCK: begin
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                if (last_idx) touched_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q       <= CMD_NOP;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            coord_x_q   <= '0;
            coord_y_q   <= '0;
            idx_q       <= '0;
            rd_pend_q   <= 1'b0;
            blocked_q   <= 1'b0;
            moved_q     <= 1'b0;
            touched_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            coord_x_q   <= coord_x_d;
            coord_y_q   <= coord_y_d;
            idx_q       <= idx_d;
            rd_pend_q   <= rd_pend_d;
            blocked_q   <= blocked_d;
            moved_q     <= moved_d;
            touched_q   <= touched_d;
            game_over_q <= game_over_d;
        end
    end

    // --------------------------------------------------------------- outputs
    // Strobes decode straight from the state register, so an asynchronous
    // reset drops a lock write in the same cycle.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        occ_rd    = (state_q == ST_CHECK);
        occ_x     = cand_x_q[int'(idx_q)*WIDTH +: WIDTH];
        occ_y     = cand_y_q[int'(idx_q)*WIDTH +: WIDTH];
        wr_en     = (state_q == ST_LOCK);
        wr_x      = coord_x_q[int'(idx_q)*WIDTH +: WIDTH];
        wr_y      = coord_y_q[int'(idx_q)*WIDTH +: WIDTH];
        done      = (state_q == ST_DONE);
        moved     = done && moved_q;
        touched   = done && touched_q;
        game_over = game_over_q;
        coord_x   = coord_x_q;
        coord_y   = coord_y_q;
    end

endmodule

// File: tb/tb_piece_move_engine.sv
// -----------------------------------------------------------------------------
// tb_piece_move_engine
//   Directed bench for piece_move_engine with default geometry (WIDTH=8,
//   CELLS=4, 10x20 field). Cycle numbers are counted from the accept edge:
//   the first negedge after it is cycle 1. The occupancy RAM is modelled by a
//   per-read hit mask answered one cycle after each occ_rd.
// -----------------------------------------------------------------------------
module tb_piece_move_engine;
    import tetris_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd = 3'd0;
    logic [C*W-1:0] load_x = '0, load_y = '0;
    logic           occ_rd;
    logic [W-1:0]   occ_x, occ_y;
    logic           occ_hit = 1'b0;
    logic           wr_en;
    logic [W-1:0]   wr_x, wr_y;
    logic [C*W-1:0] coord_x, coord_y;
    logic           done, moved, touched, game_over;

    int checks = 0;
    int errors = 0;

    // Results captured by run_cmd.
    int         r_cyc, r_rd, r_wr;
    logic       r_moved, r_touched;
    logic [7:0] r_rd_x[8], r_rd_y[8], r_wr_x[8], r_wr_y[8];

    piece_move_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .load_x(load_x), .load_y(load_y), .occ_rd(occ_rd), .occ_x(occ_x), .occ_y(occ_y),
        .occ_hit(occ_hit), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .coord_x(coord_x),
        .coord_y(coord_y), .done(done), .moved(moved), .touched(touched), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic run_cmd(input logic [2:0] c, input logic [31:0] lx, input logic [31:0] ly,
                           input logic [3:0] hit_mask);
        logic pend;
        pend = 1'b0; r_cyc = -1; r_rd = 0; r_wr = 0; r_moved = 1'b0; r_touched = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready); end
        cmd = c; load_x = lx; load_y = ly; cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            occ_hit = pend; pend = 1'b0;
            if (occ_rd === 1'b1) begin
                if (r_rd < 8) begin r_rd_x[r_rd] = occ_x; r_rd_y[r_rd] = occ_y; end
                pend = (r_rd < C) ? hit_mask[r_rd] : 1'b0;
                r_rd++;
            end
            if (wr_en === 1'b1) begin
                if (r_wr < 8) begin r_wr_x[r_wr] = wr_x; r_wr_y[r_wr] = wr_y; end
                r_wr++;
            end
            if (done === 1'b1) begin r_cyc = n; r_moved = moved; r_touched = touched; break; end
        end
        occ_hit = 1'b0;
        checks++; if (r_cyc < 0) begin errors++; $display("FAIL done_timeout cmd=%0d no done within 40 cycles", c); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({done, moved, touched, occ_rd, wr_en, game_over} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b want 000000", {done, moved, touched, occ_rd, wr_en, game_over}); end
        checks++; if ({coord_x, coord_y} !== 64'd0) begin errors++; $display("FAIL rst_coords got %h want 0", {coord_x, coord_y}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_release_done got %b want 0", done); end
    endtask

    task automatic test_load_clean();
        run_cmd(CMD_LOAD, pk(4, 5, 4, 5), pk(0, 0, 1, 1), 4'b0000);
        checks++; if (r_cyc !== 6) begin errors++; $display("FAIL load_done_cycle got %0d want 6", r_cyc); end
        checks++; if ({r_moved, r_touched} !== 2'b10) begin errors++; $display("FAIL load_flags got %b want 10", {r_moved, r_touched}); end
        checks++; if (r_rd !== 4) begin errors++; $display("FAIL load_reads got %0d want 4", r_rd); end
        checks++; if ({r_rd_x[0], r_rd_y[0], r_rd_x[3], r_rd_y[3]} !== {8'd4, 8'd0, 8'd5, 8'd1}) begin errors++; $display("FAIL load_read_coords got %h want 04000501", {r_rd_x[0], r_rd_y[0], r_rd_x[3], r_rd_y[3]}); end
        checks++; if ({coord_x, coord_y} !== {pk(4, 5, 4, 5), pk(0, 0, 1, 1)}) begin errors++; $display("FAIL load_coords got %h", {coord_x, coord_y}); end
    endtask

    task automatic test_down_clean();
        run_cmd(CMD_DOWN, '0, '0, 4'b0000);
        checks++; if (r_cyc !== 6) begin errors++; $display("FAIL down_done_cycle got %0d want 6", r_cyc); end
        checks++; if (r_rd !== 4) begin errors++; $display("FAIL down_reads got %0d want 4", r_rd); end
        checks++; if ({r_rd_x[2], r_rd_y[2]} !== {8'd4, 8'd2}) begin errors++; $display("FAIL down_read2 got %h want 0402", {r_rd_x[2], r_rd_y[2]}); end
        checks++; if ({r_moved, r_touched} !== 2'b10) begin errors++; $display("FAIL down_flags got %b want 10", {r_moved, r_touched}); end
        checks++; if (coord_y !== pk(1, 1, 2, 2)) begin errors++; $display("FAIL down_coord_y got %h want %h", coord_y, pk(1, 1, 2, 2)); end
        checks++; if (coord_x !== pk(4, 5, 4, 5)) begin errors++; $display("FAIL down_coord_x got %h", coord_x); end
        @(negedge clk);
        checks++; if ({done, moved} !== 2'b00) begin errors++; $display("FAIL down_flags_after got %b want 00", {done, moved}); end
    endtask

    task automatic test_nop();
        run_cmd(CMD_NOP, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_rd, r_moved} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL nop got cyc=%0d rd=%0d moved=%b want 1 0 0", r_cyc, r_rd, r_moved); end
        run_cmd(3'd7, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_moved} !== {32'd1, 1'b0}) begin errors++; $display("FAIL cmd7 got cyc=%0d moved=%b want 1 0", r_cyc, r_moved); end
        checks++; if (coord_y !== pk(1, 1, 2, 2)) begin errors++; $display("FAIL nop_coords got %h", coord_y); end
    endtask

    task automatic test_rotate();
        run_cmd(CMD_ROT_CW, '0, '0, 4'b0000);
`ifdef PIECE_ROTATE_EN
        checks++; if ({r_cyc, r_moved} !== {32'd6, 1'b1}) begin errors++; $display("FAIL rot got cyc=%0d moved=%b want 6 1", r_cyc, r_moved); end
        checks++; if ({coord_x, coord_y} !== {pk(4, 4, 3, 3), pk(1, 2, 1, 2)}) begin errors++; $display("FAIL rot_coords got %h", {coord_x, coord_y}); end
`else
        checks++; if ({r_cyc, r_rd, r_moved} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL rot_off got cyc=%0d rd=%0d moved=%b want 1 0 0", r_cyc, r_rd, r_moved); end
        checks++; if ({coord_x, coord_y} !== {pk(4, 5, 4, 5), pk(1, 1, 2, 2)}) begin errors++; $display("FAIL rot_off_coords got %h", {coord_x, coord_y}); end
`endif
    endtask

    task automatic test_horizontal_edges();
        run_cmd(CMD_LOAD, pk(0, 1, 0, 1), pk(5, 5, 6, 6), 4'b0000);
        run_cmd(CMD_LEFT, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_rd, r_moved, r_touched} !== {32'd1, 32'd0, 2'b00}) begin errors++; $display("FAIL left_edge got cyc=%0d rd=%0d m=%b t=%b want 1 0 0 0", r_cyc, r_rd, r_moved, r_touched); end
        checks++; if (coord_x !== pk(0, 1, 0, 1)) begin errors++; $display("FAIL left_edge_coords got %h", coord_x); end
        run_cmd(CMD_RIGHT, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_moved} !== {32'd6, 1'b1}) begin errors++; $display("FAIL right_clean got cyc=%0d moved=%b want 6 1", r_cyc, r_moved); end
        checks++; if (coord_x !== pk(1, 2, 1, 2)) begin errors++; $display("FAIL right_clean_coords got %h", coord_x); end
        run_cmd(CMD_LOAD, pk(8, 9, 8, 9), pk(5, 5, 6, 6), 4'b0000);
        run_cmd(CMD_RIGHT, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_rd, r_moved} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL right_edge got cyc=%0d rd=%0d moved=%b want 1 0 0", r_cyc, r_rd, r_moved); end
        run_cmd(CMD_LEFT, '0, '0, 4'b0001);
        checks++; if ({r_cyc, r_rd, r_wr, r_moved, r_touched} !== {32'd6, 32'd4, 32'd0, 2'b00}) begin errors++; $display("FAIL left_hit got cyc=%0d rd=%0d wr=%0d m=%b t=%b", r_cyc, r_rd, r_wr, r_moved, r_touched); end
        checks++; if (coord_x !== pk(8, 9, 8, 9)) begin errors++; $display("FAIL left_hit_coords got %h", coord_x); end
    endtask

    task automatic test_lock_on_hit();
        run_cmd(CMD_LOAD, pk(4, 5, 4, 5), pk(10, 10, 11, 11), 4'b0000);
        run_cmd(CMD_DOWN, '0, '0, 4'b0100);
        checks++; if (r_cyc !== 10) begin errors++; $display("FAIL lock_done_cycle got %0d want 10", r_cyc); end
        checks++; if ({r_moved, r_touched} !== 2'b01) begin errors++; $display("FAIL lock_flags got %b want 01", {r_moved, r_touched}); end
        checks++; if (r_wr !== 4) begin errors++; $display("FAIL lock_writes got %0d want 4", r_wr); end
        checks++; if ({r_wr_x[0], r_wr_y[0], r_wr_x[1], r_wr_y[1], r_wr_x[2], r_wr_y[2], r_wr_x[3], r_wr_y[3]} !== 64'h040a050a040b050b) begin errors++; $display("FAIL lock_write_coords got %h want 040a050a040b050b", {r_wr_x[0], r_wr_y[0], r_wr_x[1], r_wr_y[1], r_wr_x[2], r_wr_y[2], r_wr_x[3], r_wr_y[3]}); end
        checks++; if (coord_y !== pk(10, 10, 11, 11)) begin errors++; $display("FAIL lock_coords got %h", coord_y); end
    endtask

    task automatic test_floor_lock();
        run_cmd(CMD_LOAD, pk(4, 5, 4, 5), pk(18, 18, 19, 19), 4'b0000);
        run_cmd(CMD_DOWN, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_rd, r_wr, r_moved, r_touched} !== {32'd5, 32'd0, 32'd4, 2'b01}) begin errors++; $display("FAIL floor got cyc=%0d rd=%0d wr=%0d m=%b t=%b want 5 0 4 0 1", r_cyc, r_rd, r_wr, r_moved, r_touched); end
        checks++; if ({r_wr_x[3], r_wr_y[3]} !== {8'd5, 8'd19}) begin errors++; $display("FAIL floor_write3 got %h want 0513", {r_wr_x[3], r_wr_y[3]}); end
    endtask

    task automatic test_reset_mid_lock();
        @(negedge clk);
        cmd = CMD_DOWN; cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if ({wr_en, wr_x, wr_y} !== {1'b1, 8'd4, 8'd18}) begin errors++; $display("FAIL midlock_c1 got %b %h %h want 1 04 12", wr_en, wr_x, wr_y); end
        @(negedge clk);
        checks++; if ({wr_en, wr_x} !== {1'b1, 8'd5}) begin errors++; $display("FAIL midlock_c2 got %b %h want 1 05", wr_en, wr_x); end
        rst = 1'b0; #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midlock_wr_drop got %b want 0", wr_en); end
        checks++; if ({coord_x, coord_y} !== 64'd0) begin errors++; $display("FAIL midlock_coords got %h want 0", {coord_x, coord_y}); end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if ({wr_en, done} !== 2'b00) begin errors++; $display("FAIL midlock_after got wr=%b done=%b want 0 0", wr_en, done); end
        end
        checks++; if ({cmd_ready, game_over} !== 2'b10) begin errors++; $display("FAIL midlock_idle got %b want 10", {cmd_ready, game_over}); end
    endtask

    task automatic test_game_over();
        run_cmd(CMD_LOAD, pk(4, 5, 4, 5), pk(0, 0, 1, 1), 4'b0001);
        checks++; if ({r_cyc, r_moved, r_touched} !== {32'd6, 2'b00}) begin errors++; $display("FAIL go_load got cyc=%0d m=%b t=%b want 6 0 0", r_cyc, r_moved, r_touched); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_flag got %b want 1", game_over); end
        checks++; if ({coord_x, coord_y} !== {pk(4, 5, 4, 5), pk(0, 0, 1, 1)}) begin errors++; $display("FAIL go_coords got %h", {coord_x, coord_y}); end
        run_cmd(CMD_RIGHT, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_rd, r_moved} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL go_right got cyc=%0d rd=%0d moved=%b want 1 0 0", r_cyc, r_rd, r_moved); end
        run_cmd(CMD_DOWN, '0, '0, 4'b0000);
        checks++; if ({r_cyc, r_wr, r_touched} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL go_down got cyc=%0d wr=%0d t=%b want 1 0 0", r_cyc, r_wr, r_touched); end
        run_cmd(CMD_LOAD, pk(1, 2, 1, 2), pk(3, 3, 4, 4), 4'b0000);
        checks++; if ({r_cyc, r_moved, game_over} !== {32'd6, 2'b11}) begin errors++; $display("FAIL go_reload got cyc=%0d moved=%b go=%b want 6 1 1", r_cyc, r_moved, game_over); end
    endtask

    initial begin
        test_reset();
        test_load_clean();
        test_down_clean();
        test_nop();
        test_rotate();
        test_horizontal_edges();
        test_lock_on_hit();
        test_floor_lock();
        test_reset_mid_lock();
        test_game_over();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
